puf_challenge_sequencer: RTL

PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

---
 rtl/puf_pkg.sv | 18 +
 rtl/puf_settle_timer.sv | 30 +++
 rtl/puf_challenge_sequencer.sv | 90 +++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// Shared definitions for the PUF challenge sequencer: default geometry and FSM encoding.
package puf_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_SETTLE = 4;
  localparam int unsigned DEF_NRESP  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_STEP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/puf_settle_timer.sv
// Arbiter settle timer: cleared by load, counts while run, flags the final settle cycle.
module puf_settle_timer #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(N) + 1;

  logic [CW-1:0] count;

  always_comb begin
    expired = run && (count == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sequences LFSR load/step and arbiter races, shifting NRESP response bits into a word.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned SETTLE = DEF_SETTLE,
  parameter int unsigned NRESP  = DEF_NRESP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_load,
  output logic             lfsr_inc,
  output logic             puf_fire,
  input  logic             puf_response,
  output logic [NRESP-1:0] response_word,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = $clog2(NRESP) + 1;

  state_t        state;
  state_t        next;
  logic [BW-1:0] bit_cnt;
  logic          settle_exp;
  logic          last_bit;

  puf_settle_timer #(
    .N (SETTLE)
  ) u_settle (
    .clk     (clk),
    .reset   (reset),
    .load    (state == ST_FIRE),
    .run     (state == ST_SETTLE),
    .expired (settle_exp)
  );

  always_comb begin
    last_bit = (bit_cnt == BW'(NRESP - 1));
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE:   if (start) next = ST_LOAD;
      ST_LOAD:   next = ST_FIRE;
      ST_FIRE:   next = ST_SETTLE;
      ST_SETTLE: if (settle_exp) next = ST_SAMPLE;
      ST_SAMPLE: next = last_bit ? ST_DONE : ST_STEP;
      ST_STEP:   next = ST_FIRE;
      ST_DONE:   next = ST_IDLE;
      default:   next = ST_IDLE;
    endcase
  end

  // Pulse outputs are flopped from the next-state decode so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      lfsr_seed     <= '0;
      response_word <= '0;
      bit_cnt       <= '0;
      lfsr_load     <= 1'b0;
      lfsr_inc      <= 1'b0;
      puf_fire      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state     <= next;
      lfsr_load <= (next == ST_LOAD);
      lfsr_inc  <= (next == ST_STEP);
      puf_fire  <= (next == ST_FIRE);
      busy      <= (next != ST_IDLE);
      done      <= (next == ST_DONE);
      if (state == ST_IDLE && start) begin
        lfsr_seed     <= seed;
        response_word <= '0;
        bit_cnt       <= '0;
      end
      if (state == ST_SAMPLE) begin
        response_word <= {response_word[NRESP-2:0], puf_response};
        bit_cnt       <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
